fir_engine_mac: RTL and testbench
=================================

Name: fir_engine_mac

Overview:
- Parametrised successor to the fixed-shape FIR scalar-product engine.
- Computes NB_LANES signed lane products per input beat and sums them. It either accumulates the sums over len beats (dot mode) or emits one result per beat (simple_mul mode). Each result gets a streamed bias c added, is arithmetically right-shifted, and is emitted on a valid/ready output stream.
- Sits between the streamer sources (a, b, c) and sink (d), driven by the control FSM through enable/clear/start and configuration inputs.

Parameters:
- NB_LANES, 4: parallel multiply lanes per beat.
- DATA_WIDTH, 16: signed width of each a/b lane.
- ACC_WIDTH, 48: signed accumulator width; must be >= 2*DATA_WIDTH+$clog2(NB_LANES*CNT_LEN).
- OUT_WIDTH, 32: signed width of c and d.
- CNT_LEN, 1024: maximum len; counter width CW=$clog2(CNT_LEN)+1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- clear_i  in  1  synchronous abort/clear.
- enable_i  in  1  global enable.
- start_i  in  1  start pulse.
- simple_mul_i  in  1  mode: 1 = per-beat output, 0 = dot product.
- shift_i  in  $clog2(ACC_WIDTH)  arithmetic right shift.
- len_i  in  CW  number of beats.
- a_data_i  in  NB_LANES*DATA_WIDTH  lane operands A; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- a_valid_i  in  1.
- a_ready_o  out  1.
- b_data_i  in  NB_LANES*DATA_WIDTH  lane operands B.
- b_valid_i  in  1.
- b_ready_o  out  1.
- c_data_i  in  OUT_WIDTH  bias.
- c_valid_i  in  1.
- c_ready_o  out  1.
- d_data_o  out  OUT_WIDTH  result.
- d_valid_o  out  1.
- d_ready_i  in  1.
- cnt_o  out  CW  beats accepted in current job.
- acc_valid_o  out  1  one-cycle job-done pulse.
- busy_o  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low. On reset, state=IDLE and all outputs are 0, including all readies, d_valid_o, d_data_o, cnt_o, acc_valid_o and busy_o. Accumulator and product register are cleared.
- States are IDLE, ACCUM, BIAS, OUT.
- IDLE:
  - Readies are 0.
  - start_i & enable_i & (len_i != 0): latch len, shift and simple_mul; cnt=0; acc=0; go to ACCUM.
  - start_i with len_i == 0 is ignored (stays IDLE, no output).
  - start_i in any other state is ignored.
- ACCUM:
  - a_ready_o = b_ready_o = enable_i & (cnt < len) & !product_reg_valid_pending_for_simple_mul.
  - A beat fires only when both a and b handshake in the same cycle. Ready does not depend on valid.
  - Beat processing:
    - Each lane product is signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH.
    - The lane products are summed, sign-extended to ACC_WIDTH, and registered (product stage, 1 cycle).
    - On the next cycle the registered sum is added into acc. Overflow wraps mod 2^ACC_WIDTH.
    - cnt_o increments on the handshake cycle.
  - Dot mode: after the len-th beat's product is added, go to BIAS. The final beat handshake at cycle t puts BIAS at cycle t+2.
  - simple_mul mode: after each beat's product is added (acc cleared before each beat), go to BIAS.
- BIAS:
  - c_ready_o = enable_i.
  - On c handshake, d_data_o <= sat_or_trunc((acc + sext(c_data_i)) >>> shift), then go to OUT. d_valid_o rises the cycle after the c handshake.
- OUT:
  - d_valid_o = 1; d_data_o is stable until d_ready_i.
  - The d handshake completes regardless of enable_i.
  - On handshake:
    - If cnt == len: go to IDLE and pulse acc_valid_o for 1 cycle.
    - Else (simple_mul only): clear acc and return to ACCUM.
- enable_i = 0 freezes state, acc, cnt and the product stage, and drops a/b/c readies. A pending d_valid_o stays asserted.
- clear_i has the highest priority over start and handshakes. Next cycle: state IDLE, acc/cnt/product stage zeroed, d_valid_o = 0. clear_i is the only case in which d_valid_o drops without a handshake.
- cnt_o holds its final value in IDLE until the next start.

Optional Feature:
- Macro: FIR_ENGINE_SATURATE_EN.
- Defined: the shifted result is saturated to the signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: the result is truncated to its OUT_WIDTH LSBs.

Test Plan:
- Dot mode, len=2, a lanes=[1,1,1,1], b lanes=[1,2,3,4] on both beats, c=10, shift=0 -> single d=30; acc_valid_o pulse after the d handshake; cnt_o=2; busy_o low afterwards.
- simple_mul, len=3, a=[2,2,2,2], b=[3,3,3,3], c=0 per beat, shift=1 -> three d outputs of 12; acc_valid_o pulses only after the third.
- Signed: len=1, a lanes=0xFFFF (-1), b lanes=5, c=0, shift=2 -> d=0xFFFFFFFB (-5).
- Backpressure: d_ready_i low for 5 cycles in OUT -> d_valid_o stays high, d_data_o unchanged, a/b/c readies 0. Raise ready -> one handshake, then IDLE.
- clear_i after beat 1 of len=4 -> IDLE next cycle, cnt_o=0, no d output. Subsequent start with len=1 completes normally. start with len_i=0 -> stays IDLE.
- Overflow: acc=2^40, c=0, shift=0 -> d=0x7FFFFFFF with FIR_ENGINE_SATURATE_EN, d=0x00000000 without.

Source files
------------

// File: rtl/fir_engine_mac.sv
// fir_engine_mac: multi-lane signed MAC with streamed bias, arithmetic shift and valid/ready result output.
// Define FIR_ENGINE_SATURATE_EN to saturate the result to OUT_WIDTH instead of truncating it.
module fir_engine_mac #(
    parameter int NB_LANES   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 32,
    parameter int CNT_LEN    = 1024,
    localparam int CW        = $clog2(CNT_LEN) + 1,
    localparam int SW        = $clog2(ACC_WIDTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           enable_i,
    input  logic                           start_i,
    input  logic                           simple_mul_i,
    input  logic [SW-1:0]                  shift_i,
    input  logic [CW-1:0]                  len_i,
    input  logic [NB_LANES*DATA_WIDTH-1:0] a_data_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    input  logic [NB_LANES*DATA_WIDTH-1:0] b_data_i,
    input  logic                           b_valid_i,
    output logic                           b_ready_o,
    input  logic [OUT_WIDTH-1:0]           c_data_i,
    input  logic                           c_valid_i,
    output logic                           c_ready_o,
    output logic [OUT_WIDTH-1:0]           d_data_o,
    output logic                           d_valid_o,
    input  logic                           d_ready_i,
    output logic [CW-1:0]                  cnt_o,
    output logic                           acc_valid_o,
    output logic                           busy_o
);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, BIAS = 2'd2, OUT = 2'd3;

    logic [1:0]               state;
    logic [CW-1:0]            cnt, len_q;
    logic [SW-1:0]            shift_q;
    logic                     simple_q, prod_vld;
    logic [ACC_WIDTH-1:0]     acc, prod, lane_sum;
    logic signed [ACC_WIDTH:0] biased;
    logic [OUT_WIDTH-1:0]     d_next;
    logic                     ab_ready, ab_fire, c_fire, d_fire;

    // in simple_mul mode a new beat waits until the previous one has been emitted
    assign ab_ready  = (state == ACCUM) && enable_i && (cnt < len_q) && !(simple_q && prod_vld);
    assign a_ready_o = ab_ready;
    assign b_ready_o = ab_ready;
    assign ab_fire   = ab_ready && a_valid_i && b_valid_i;
    assign c_ready_o = (state == BIAS) && enable_i;
    assign c_fire    = c_ready_o && c_valid_i;
    assign d_valid_o = (state == OUT);
    assign d_fire    = d_valid_o && d_ready_i;
    assign busy_o    = (state != IDLE);
    assign cnt_o     = cnt;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < NB_LANES; k++)
            lane_sum = lane_sum + ACC_WIDTH'($signed(a_data_i[k*DATA_WIDTH +: DATA_WIDTH]) *
                                             $signed(b_data_i[k*DATA_WIDTH +: DATA_WIDTH]));
    end

    // one extra bit so the bias addition itself cannot wrap
    assign biased = $signed({acc[ACC_WIDTH-1], acc}) + (ACC_WIDTH+1)'($signed(c_data_i));

`ifdef FIR_ENGINE_SATURATE_EN
    logic signed [ACC_WIDTH:0] shifted;
    assign shifted = biased >>> shift_q;
    assign d_next  = (&shifted[ACC_WIDTH:OUT_WIDTH-1] || ~|shifted[ACC_WIDTH:OUT_WIDTH-1])
                   ? shifted[OUT_WIDTH-1:0]
                   : {shifted[ACC_WIDTH], {(OUT_WIDTH-1){~shifted[ACC_WIDTH]}}};
`else
    assign d_next  = OUT_WIDTH'(biased >>> shift_q);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            simple_q    <= 1'b0;
            prod_vld    <= 1'b0;
            prod        <= '0;
            acc         <= '0;
            d_data_o    <= '0;
            acc_valid_o <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            cnt         <= '0;
            prod_vld    <= 1'b0;
            prod        <= '0;
            acc         <= '0;
            acc_valid_o <= 1'b0;
        end else begin
            acc_valid_o <= 1'b0;
            case (state)
                IDLE: if (start_i && enable_i && len_i != '0) begin
                    state    <= ACCUM;
                    len_q    <= len_i;
                    shift_q  <= shift_i;
                    simple_q <= simple_mul_i;
                    cnt      <= '0;
                    acc      <= '0;
                end
                ACCUM: if (enable_i) begin
                    prod_vld <= ab_fire;
                    if (ab_fire) begin
                        prod <= lane_sum;
                        cnt  <= cnt + CW'(1);
                    end
                    if (prod_vld) begin
                        acc <= acc + prod;
                        if (simple_q || cnt == len_q) state <= BIAS;
                    end
                end
                BIAS: if (c_fire) begin
                    d_data_o <= d_next;
                    state    <= OUT;
                end
                OUT: if (d_fire) begin
                    if (cnt == len_q) begin
                        state       <= IDLE;
                        acc_valid_o <= 1'b1;
                    end else begin
                        state <= ACCUM;
                        acc   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_engine_mac.sv
// tb_fir_engine_mac: directed and randomized jobs checked against an integer-arithmetic reference model.
module tb_fir_engine_mac;
    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, enable = 1'b1, start = 1'b0, simple = 1'b0;
    logic [5:0]  shift = '0;
    logic [10:0] len = '0;
    logic [63:0] a_data = '0, b_data = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0, d_ready = 1'b0;
    logic        a_ready, b_ready, c_ready, d_valid, acc_valid, busy;
    logic [31:0] c_data = '0, d_data;
    logic [10:0] cnt;
    int          n_checks = 0, n_fails = 0;

    fir_engine_mac dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .start_i(start),
        .simple_mul_i(simple), .shift_i(shift), .len_i(len),
        .a_data_i(a_data), .a_valid_i(a_valid), .a_ready_o(a_ready),
        .b_data_i(b_data), .b_valid_i(b_valid), .b_ready_o(b_ready),
        .c_data_i(c_data), .c_valid_i(c_valid), .c_ready_o(c_ready),
        .d_data_o(d_data), .d_valid_o(d_valid), .d_ready_i(d_ready),
        .cnt_o(cnt), .acc_valid_o(acc_valid), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint dotp(input logic [63:0] a, input logic [63:0] b);
        longint s = 0;
        for (int k = 0; k < 4; k++)
            s += longint'($signed(a[k*16 +: 16])) * longint'($signed(b[k*16 +: 16]));
        return s;
    endfunction

    function automatic logic [31:0] expect_d(input longint acc, input logic [31:0] c, input int sh);
        longint v = (acc + longint'($signed(c))) >>> sh;
`ifdef FIR_ENGINE_SATURATE_EN
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        else if (v < -64'sd2147483648) v = -64'sd2147483648;
`endif
        return v[31:0];
    endfunction

    task automatic start_job(input bit sm, input int l, input int sh);
        @(negedge clk);
        start = 1'b1; simple = sm; len = l[10:0]; shift = sh[5:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        @(negedge clk);
        a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
        while (!(a_ready && b_ready) && n < 50) begin @(negedge clk); n++; end
        chk("ab_ready", {a_ready, b_ready}, 2'b11);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic bias(input logic [31:0] c);
        int n = 0;
        @(negedge clk);
        c_data = c; c_valid = 1'b1;
        while (!c_ready && n < 50) begin @(negedge clk); n++; end
        chk("c_ready", c_ready, 1'b1);
        @(negedge clk);
        c_valid = 1'b0;
    endtask

    task automatic take_d(input logic [31:0] e, input bit last, input string tag);
        int n = 0;
        @(negedge clk);
        d_ready = 1'b1;
        while (!d_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, d_valid, 1'b1);
        chk({tag, "_data"}, d_data, e);
        @(negedge clk);
        d_ready = 1'b0;
        chk({tag, "_acc_valid"}, acc_valid, last);
        chk({tag, "_busy"}, busy, !last);
        chk({tag, "_d_drop"}, d_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] ra, rb, ones, b1234;
        logic [31:0] rc;
        longint      acc;
        int          l, sh;
        bit          sm;
        ones  = {4{16'd1}};
        b1234 = {16'd4, 16'd3, 16'd2, 16'd1};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {a_ready, b_ready, c_ready, d_valid, acc_valid, busy}, 6'b0);
        chk("reset_data", {d_data, cnt}, 43'b0);
        rst_n = 1'b1;

        start_job(0, 2, 0);
        beat(ones, b1234);
        enable = 1'b0;
        @(negedge clk);
        chk("freeze_ready", a_ready, 1'b0);
        chk("freeze_cnt", cnt, 11'd1);
        enable = 1'b1;
        beat(ones, b1234);
        bias(32'd10);
        take_d(32'd30, 1, "dot");
        chk("dot_cnt", cnt, 11'd2);

        start_job(1, 3, 1);
        for (int i = 0; i < 3; i++) begin
            beat({4{16'd2}}, {4{16'd3}});
            bias(32'd0);
            take_d(32'd12, i == 2, "simple");
        end

        start_job(0, 1, 2);
        beat({4{16'hFFFF}}, {4{16'd5}});
        bias(32'd0);
        take_d(32'hFFFFFFFB, 1, "signed");

        ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = $urandom;
        start_job(0, 1, 0);
        beat(ra, rb);
        bias(rc);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", d_valid, 1'b1);
            chk("bp_data", d_data, expect_d(dotp(ra, rb), rc, 0));
            chk("bp_readies", {a_ready, b_ready, c_ready}, 3'b0);
        end
        take_d(expect_d(dotp(ra, rb), rc, 0), 1, "bp");

        start_job(0, 4, 0);
        beat(ra, rb);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_busy", busy, 1'b0);
        chk("clear_cnt", cnt, 11'd0);
        chk("clear_d_valid", d_valid, 1'b0);
        start_job(0, 1, 3);
        beat(rb, ra);
        bias(32'd7);
        take_d(expect_d(dotp(rb, ra), 32'd7, 3), 1, "after_clear");
        start_job(0, 0, 0);
        chk("len0_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("len0_d_valid", d_valid, 1'b0);

        for (int j = 0; j < 8; j++) begin
            sm = 1'($urandom_range(0, 1));
            l  = int'($urandom_range(1, 5));
            sh = int'($urandom_range(0, 15));
            start_job(sm, l, sh);
            acc = 0;
            for (int i = 0; i < l; i++) begin
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
                beat(ra, rb);
                acc = sm ? dotp(ra, rb) : acc + dotp(ra, rb);
                if (sm || i == l - 1) begin
                    rc = $urandom;
                    bias(rc);
                    take_d(expect_d(acc, rc, sh), i == l - 1, "rand");
                end
            end
            chk("rand_cnt", cnt, l[10:0]);
        end

        start_job(0, 256, 0);
        acc = 0;
        for (int i = 0; i < 256; i++) begin
            beat({4{16'h8000}}, {4{16'h8000}});
            acc += dotp({4{16'h8000}}, {4{16'h8000}});
        end
        bias(32'd0);
        take_d(expect_d(acc, 32'd0, 0), 1, "overflow");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
